// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT sizing, sequencer state encoding and butterfly pair tag
package fft_pkg;
   localparam int LOG2N   = 10;
   localparam int PAIRS   = 2 ** (LOG2N - 1);
   localparam int STAGE_W = 4;
   localparam int PAIR_W  = 9;
   typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_DRAIN, SEQ_DONE} seq_state_t;
   typedef struct packed {
      logic               valid;
      logic [STAGE_W-1:0] stage;
      logic [PAIR_W-1:0]  pair;
   } pair_tag_t;
endpackage

// File: rtl/fft_tag_pipe.sv
// fft_tag_pipe: fixed-latency shift register of pair tags feeding the write-side address generator
module fft_tag_pipe
   import fft_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      i_clk,
   input  logic      i_rst_n,
   input  logic      i_flush,
   input  pair_tag_t i_tag,
   output pair_tag_t o_tag,
   output logic      o_empty
);
   pair_tag_t pipe [DEPTH];
   // shift one slot per cycle; flush drops every tag on the same edge
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n || i_flush) begin
         for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= i_tag;
         for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
   end
   // the tail is the write happening this cycle, so only the slots behind it can still be pending
   always_comb begin
      o_empty = 1'b1;
      for (int i = 0; i < DEPTH - 1; i++) if (pipe[i].valid) o_empty = 1'b0;
   end
   assign o_tag = pipe[DEPTH-1];
endmodule

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: issues every butterfly pair of every FFT stage and drains between stages
module fft_stage_sequencer
   import fft_pkg::*;
#(
   parameter int PIPE_LAT = 4
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic               i_hold,
   input  logic               i_abort,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_rd_en,
   output logic [STAGE_W-1:0] o_rd_stage,
   output logic [PAIR_W-1:0]  o_rd_pair,
   output logic               o_wr_en,
   output logic [STAGE_W-1:0] o_wr_stage,
   output logic [PAIR_W-1:0]  o_wr_pair,
   output logic               o_result_mem1
);
   localparam logic [1:0] IDLE  = SEQ_IDLE;
   localparam logic [1:0] RUN   = SEQ_RUN;
   localparam logic [1:0] DRAIN = SEQ_DRAIN;
   localparam logic [1:0] DONE  = SEQ_DONE;
   localparam logic RESULT_MEM1 = ((LOG2N - 1) % 2) == 1;
   logic [1:0]         state;
   logic [STAGE_W-1:0] stage;
   logic [PAIR_W-1:0]  pair;
   logic               issue;
   logic               drained;
   pair_tag_t          tail;
   assign issue = (state == RUN) && !i_hold;
   // stage/pair walk; abort wins over every other event
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state         <= IDLE;
         stage         <= '0;
         pair          <= '0;
         o_result_mem1 <= 1'b0;
      end else if (i_abort) begin
         state <= IDLE;
         stage <= '0;
         pair  <= '0;
      end else begin
         case (state)
            IDLE: if (i_start) begin
               state <= RUN;
               stage <= '0;
               pair  <= '0;
            end
            RUN: if (issue) begin
               if (pair == PAIR_W'(PAIRS - 1)) state <= DRAIN;
               else pair <= pair + 1'b1;
            end
            DRAIN: if (drained) begin
               if (stage == STAGE_W'(LOG2N - 1)) begin
                  state         <= DONE;
                  o_result_mem1 <= RESULT_MEM1;
               end else begin
                  state <= RUN;
                  stage <= stage + 1'b1;
                  pair  <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
   fft_tag_pipe #(.DEPTH(PIPE_LAT)) u_pipe (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_flush (i_abort),
      .i_tag   ('{valid: issue, stage: stage, pair: pair}),
      .o_tag   (tail),
      .o_empty (drained)
   );
   assign o_busy     = (state == RUN) || (state == DRAIN);
   assign o_done     = state == DONE;
   assign o_rd_en    = issue;
   assign o_rd_stage = stage;
   assign o_rd_pair  = pair;
   assign o_wr_en    = tail.valid;
   assign o_wr_stage = tail.stage;
   assign o_wr_pair  = tail.pair;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: table-driven run scenarios plus reset/abort corner sequences
module tb_fft_stage_sequencer;
   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_start = 1'b0;
   logic       i_hold = 1'b0;
   logic       i_abort = 1'b0;
   logic       o_busy, o_done, o_rd_en, o_wr_en, o_result_mem1;
   logic [3:0] o_rd_stage, o_wr_stage;
   logic [8:0] o_rd_pair, o_wr_pair;
   int errors = 0;
   int checks = 0;
   int issue_cyc [5120];
   typedef struct {
      string name;
      int hold_lo, hold_hi, start2, abort_at;
      int exp_done, exp_done_n, exp_issues, exp_writes;
      int exp_first_wr, exp_last_s0, exp_first_s1, exp_gaps;
   } vec_t;
   vec_t vecs [4];
   fft_stage_sequencer #(.PIPE_LAT(4)) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_start       (i_start),
      .i_hold        (i_hold),
      .i_abort       (i_abort),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_rd_en       (o_rd_en),
      .o_rd_stage    (o_rd_stage),
      .o_rd_pair     (o_rd_pair),
      .o_wr_en       (o_wr_en),
      .o_wr_stage    (o_wr_stage),
      .o_wr_pair     (o_wr_pair),
      .o_result_mem1 (o_result_mem1)
   );
   always #5 i_clk = ~i_clk;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic run_vec(input vec_t v);
      int issues = 0, writes = 0, done_n = 0, done_cyc = -1;
      int seq_err = 0, wseq_err = 0, lat_err = 0, bnd_err = 0, gaps = 0, overlap = 0;
      int first_wr = -1, last_s0 = -1, first_s1 = -1, post_abort = 0;
      for (int c = 0; c < 5300; c++) begin
         i_start = (c == 0) || (c == v.start2);
         i_hold  = (c >= v.hold_lo) && (c <= v.hold_hi);
         i_abort = (c == v.abort_at);
         #1;
         if (o_rd_en && writes < issues && int'(o_rd_stage) != writes / 512) bnd_err++;
         if (o_wr_en) begin
            if (int'(o_wr_stage) != writes / 512 || int'(o_wr_pair) != writes % 512) wseq_err++;
            if (writes >= issues || writes >= 5120 || c != issue_cyc[writes] + 4) lat_err++;
            if (writes == 0) first_wr = c;
            if (writes == 511) last_s0 = c;
            writes++;
         end
         if (o_rd_en) begin
            if (int'(o_rd_stage) != issues / 512 || int'(o_rd_pair) != issues % 512) seq_err++;
            if (issues == 512) first_s1 = c;
            if (issues < 5120) issue_cyc[issues] = c;
            issues++;
         end
         if (!o_wr_en && c >= 5 && c <= 516) gaps++;
         if (o_done) begin
            if (done_n == 0) done_cyc = c;
            done_n++;
            if (o_busy) overlap++;
         end
         if (c == v.abort_at + 1 && (o_busy || o_wr_en || o_rd_en)) post_abort++;
         @(posedge i_clk);
         #1;
      end
      i_start = 1'b0;
      i_hold  = 1'b0;
      i_abort = 1'b0;
      chk({v.name, " done_cycle"}, done_cyc, v.exp_done);
      chk({v.name, " done_pulses"}, done_n, v.exp_done_n);
      chk({v.name, " issues"}, issues, v.exp_issues);
      chk({v.name, " writes"}, writes, v.exp_writes);
      chk({v.name, " rd_sequence_errs"}, seq_err, 0);
      chk({v.name, " wr_sequence_errs"}, wseq_err, 0);
      chk({v.name, " wr_latency_errs"}, lat_err, 0);
      chk({v.name, " stage_overlap_errs"}, bnd_err, 0);
      chk({v.name, " first_wr_cycle"}, first_wr, v.exp_first_wr);
      chk({v.name, " last_s0_wr_cycle"}, last_s0, v.exp_last_s0);
      chk({v.name, " first_s1_rd_cycle"}, first_s1, v.exp_first_s1);
      chk({v.name, " s0_wr_gaps"}, gaps, v.exp_gaps);
      chk({v.name, " done_busy_overlap"}, overlap, 0);
      chk({v.name, " result_mem1"}, int'(o_result_mem1), 1);
      if (v.abort_at >= 0) chk({v.name, " post_abort_activity"}, post_abort, 0);
   endtask
   initial begin
      int nz = 0;
      vecs[0] = '{"plain",    -1, -1,  -1,   -1, 5161, 1, 5120, 5120, 5, 516, 517, 0};
      vecs[1] = '{"hold",     10, 19,  -1,   -1, 5171, 1, 5120, 5120, 5, 526, 527, 10};
      vecs[2] = '{"restart",  -1, -1, 300,   -1, 5161, 1, 5120, 5120, 5, 516, 517, 0};
      vecs[3] = '{"abort",    -1, -1,  -1, 2000,   -1, 0, 1988, 1984, 5, 516, 517, 0};
      repeat (3) @(posedge i_clk);
      #1;
      chk("reset_outputs", int'({o_busy, o_done, o_rd_en, o_rd_stage, o_rd_pair, o_wr_en,
                                 o_wr_stage, o_wr_pair, o_result_mem1}), 0);
      i_rst_n = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(posedge i_clk);
         #1;
         if ({o_busy, o_done, o_rd_en, o_rd_stage, o_rd_pair, o_wr_en, o_wr_stage, o_wr_pair,
              o_result_mem1} != '0) nz++;
      end
      chk("idle_nonzero_cycles", nz, 0);
      foreach (vecs[i]) run_vec(vecs[i]);
      for (int c = 0; c < 2000; c++) begin
         i_start = (c == 0);
         @(posedge i_clk);
         #1;
      end
      i_start = 1'b0;
      chk("pre_reset_busy", int'(o_busy), 1);
      i_rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", int'({o_busy, o_done, o_rd_en, o_rd_stage, o_rd_pair, o_wr_en,
                                       o_wr_stage, o_wr_pair, o_result_mem1}), 0);
      repeat (2) @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;
      run_vec(vecs[0]);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
